ysyx_25020047_lsu: RTL

//  Load/store unit: accepts the EXU's memory request (read/write strobe, effective address, store data, funct3)
//  and runs it on a single-outstanding word-wide data-memory bus.
//  For loads, extracts and extends the addressed byte/half/word; for stores, builds byte strobes and lane data.

---
 rtl/ysyx_25020047_lsu_if.sv | 23 ++
 rtl/ysyx_25020047_lsu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_lsu_if.sv
// Data-memory bus between the LSU (master) and the data memory (slave).
// Single outstanding, word-wide request/response channel.
interface ysyx_25020047_lsu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
  );
endinterface

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: takes one EXU memory request at a time, runs it on the
// data-memory bus, and hands one completion (data + error code) to writeback.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | ready for a request; decodes and either issues or completes
// S_REQ  | bus request presented, mem_* held until mem_req_ready
// S_RESP | waiting for the response, down-counting the timeout
// S_DONE | completion presented, rdata/err_code held until out_ready
module ysyx_25020047_lsu #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rdata,
  output logic [1:0]  err_code,
  ysyx_25020047_lsu_if.master mem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_BUS     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  state_t      state, state_nxt;
  logic [15:0] timer;
  logic        lat_read;
  logic [1:0]  lat_off;
  logic [2:0]  lat_f3;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;

  logic        f3_ld_ok, f3_st_ok, misal, req_bad, req_nop, go_bus;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;
  logic        resp_hit, tmo_hit;

  // Request decode: legality, alignment and whether the bus is needed
  always_comb begin
    f3_ld_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b101);
    f3_st_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    misal    = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    req_nop  = !read && !write;
    req_bad  = (read && write) || (read && !f3_ld_ok) || (write && !f3_st_ok) ||
               (!req_nop && misal);
    go_bus   = !req_nop && !req_bad;
  end

  // Store lane replication and byte strobes
  always_comb begin
    st_data = wdata;
    st_strb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_data = {4{wdata[7:0]}};
        st_strb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_data = {2{wdata[15:0]}};
        st_strb = 4'b0011 << addr[1:0];
      end
      default: begin
        st_data = wdata;
        st_strb = 4'b1111;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension from the latched offset
  always_comb begin
    ld_byte = 8'd0;
    case (lat_off)
      2'd0:    ld_byte = mem.mem_resp_data[7:0];
      2'd1:    ld_byte = mem.mem_resp_data[15:8];
      2'd2:    ld_byte = mem.mem_resp_data[23:16];
      default: ld_byte = mem.mem_resp_data[31:24];
    endcase
    ld_half = lat_off[1] ? mem.mem_resp_data[31:16] : mem.mem_resp_data[15:0];
    case (lat_f3)
      3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_result = {24'd0, ld_byte};
      3'b101:  ld_result = {16'd0, ld_half};
      default: ld_result = mem.mem_resp_data;
    endcase
  end

  assign resp_hit = (state == S_RESP) && mem.mem_resp_valid;
  assign tmo_hit  = (state == S_RESP) && !mem.mem_resp_valid && (timer == 16'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid)              state_nxt = go_bus ? S_REQ : S_DONE;
      S_REQ:  if (mem.mem_req_ready)     state_nxt = S_RESP;
      S_RESP: if (resp_hit || tmo_hit)   state_nxt = S_DONE;
      S_DONE: if (out_ready)             state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready          = (state == S_IDLE);
    out_valid         = (state == S_DONE);
    mem.mem_req_valid = (state == S_REQ);
    mem.mem_we        = mem_we_q;
    mem.mem_addr      = mem_addr_q;
    mem.mem_wdata     = mem_wdata_q;
    mem.mem_wstrb     = mem_wstrb_q;
  end

  // Request latches, bus registers, timeout down-counter and completion data
  always_ff @(posedge clk) begin
    if (rst) begin
      timer       <= 16'd0;
      lat_read    <= 1'b0;
      lat_off     <= 2'd0;
      lat_f3      <= 3'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
      rdata       <= 32'd0;
      err_code    <= ERR_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            lat_read <= read;
            lat_off  <= addr[1:0];
            lat_f3   <= funct3;
            if (go_bus) begin
              mem_we_q    <= write;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_wdata_q <= write ? st_data : 32'd0;
              mem_wstrb_q <= write ? st_strb : 4'b0000;
            end else begin
              rdata    <= 32'd0;
              err_code <= req_bad ? ERR_ILLEGAL : ERR_OK;
            end
          end
        end
        S_REQ: begin
          // A response seen during the handshake cycle is not legal and is dropped
          if (mem.mem_req_ready) timer <= TIMEOUT - 16'd1;
        end
        S_RESP: begin
          if (mem.mem_resp_valid) begin
            err_code <= mem.mem_resp_err ? ERR_BUS : ERR_OK;
            rdata    <= (mem.mem_resp_err || !lat_read) ? 32'd0 : ld_result;
          end else if (timer == 16'd0) begin
            err_code <= ERR_TIMEOUT;
            rdata    <= 32'd0;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
